kbd_event_ctrl: RTL
===================

// Module: kbd_event_ctrl
// PURPOSE
//  Sequences reads from the ps2_kbd scancode buffer and decodes PS/2 set-2 prefixes (E0 extended, F0 break).
//  Queues completed key events in a small FIFO for the CPU's MMIO keyboard read path.
//  Sits between ps2_kbd (data/ready/rdn) and cpu; replaces direct CPU strobing of rdn.
// PARAMETERS
//  DEPTH  8  event FIFO entries; power of 2, >= 2
//  KB_W   8  scancode byte width
// PORTS
//  clk         in   1             system clock (same as cpu and ps2_kbd)
//  rst         in   1             synchronous, active-high reset
//  kbd_ready   in   1             ps2_kbd has an unread byte on kbd_data
//  kbd_data    in   KB_W          ps2_kbd head byte, valid while kbd_ready=1
//  kbd_rdn     out  1             active-low one-cycle pop strobe to ps2_kbd
//  cpu_rd      in   1             CPU pops head event; ignored when evt_valid=0
//  evt_valid   out  1             FIFO non-empty
//  evt_data    out  KB_W+2        {brk, ext, code}; head of FIFO (first-word fall-through), 0 when empty
//  evt_count   out  $clog2(DEPTH+1)  events queued, 0..DEPTH
//  overflow    out  1             sticky: an event was dropped because the FIFO was full
//  ovf_clr     in   1             clears overflow
// BEHAVIOUR
//  Reset: state=IDLE, kbd_rdn=1, ext=brk=0, pointers=0, evt_count=0, evt_valid=0, evt_data=0, overflow=0.
//  FSM: IDLE -> POP -> GAP -> IDLE.
//   IDLE: if kbd_ready, latch kbd_data into byte_q and go to POP; else stay.
//   POP (1 cycle): kbd_rdn=0. Decode byte_q at the end of the cycle:
//     E0: ext<=1, no push.  F0: brk<=1, no push.
//     Other byte: push {brk,ext,byte_q}, then ext<=0, brk<=0.
//   GAP (1 cycle): kbd_rdn=1; lets ps2_kbd advance so kbd_ready/kbd_data are fresh; -> IDLE.
//  kbd_rdn is low only in POP: exactly one low cycle per byte. No back-to-back low cycles.
//  Latency: kbd_ready sampled high in cycle N -> rdn low in N+1 -> event visible (evt_valid=1) in N+2.
//   Peak rate is one byte per 3 cycles.
//  FIFO: push at the end of POP; pop on cpu_rd && evt_valid; pointers are log2(DEPTH) bits and wrap mod DEPTH.
//  Full with a push:
//   - No simultaneous pop: event dropped, overflow<=1, and ext/brk still cleared.
//   - Simultaneous pop: both succeed and evt_count stays at DEPTH.
//  Empty with cpu_rd: ignored; no pointer or count change. Simultaneous push: push only.
//  overflow: set has priority over ovf_clr in the same cycle.
//  Prefix-only sequences (E0 E0, F0 F0) keep the flag set and push nothing.
//  Reset mid-sequence (any state): returns to IDLE next cycle, kbd_rdn=1.
//   The pending byte and prefix flags are discarded; FIFO contents are lost.
// TESTING
//  1. Bytes 1C -> one rdn low pulse; evt_data=0x01C, evt_valid=1 two cycles after kbd_ready rises.
//  2. F0,1C -> evt_data=0x21C (brk=1); E0,F0,75 -> 0x375; E0,75 -> 0x175; exactly one event each.
//  3. Push 9 make codes with DEPTH=8 and no cpu_rd -> evt_count=8, overflow=1, head still the 1st code.
//     Then ovf_clr -> overflow=0.
//  4. FIFO full, push and cpu_rd in the same cycle -> evt_count stays 8, overflow=0, order preserved.
//  5. cpu_rd with empty FIFO -> no change. Pop 8 events after wrap-around -> FIFO order intact.
//  6. rst asserted during POP after an E0 -> next cycle kbd_rdn=1, state IDLE.
//     A following 75 yields 0x075 (ext cleared).

Source files
------------

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: pops bytes from the ps2_kbd scancode buffer, folds the
// PS/2 set-2 E0 (extended) and F0 (break) prefixes into flags, and queues
// completed key events {brk, ext, code} in a first-word fall-through FIFO
// that the CPU reads over its MMIO keyboard path.
module kbd_event_ctrl #(
  parameter int DEPTH = 8,
  parameter int KB_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kbd_ready,
  input  logic [KB_W-1:0]              kbd_data,
  output logic                         kbd_rdn,
  input  logic                         cpu_rd,
  output logic                         evt_valid,
  output logic [KB_W+1:0]              evt_data,
  output logic [$clog2(DEPTH+1)-1:0]   evt_count,
  output logic                         overflow,
  input  logic                         ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [KB_W-1:0] CODE_EXT = KB_W'(8'hE0);
  localparam logic [KB_W-1:0] CODE_BRK = KB_W'(8'hF0);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [KB_W-1:0]     byte_reg;
  logic                ext_reg;
  logic                brk_reg;

  logic [KB_W+1:0]     mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                overflow_reg;

  logic                is_ext;
  logic                is_brk;
  logic                push_req;
  logic                fifo_full;
  logic                do_pop;
  logic                do_push;
  logic                drop;

  // Next-state and pop strobe: rdn is low only while in POP, so each byte
  // gets exactly one low cycle and GAP always separates two strobes.
  always_comb begin
    state_next = state_reg;
    kbd_rdn    = 1'b1;
    case (state_reg)
      ST_IDLE: if (kbd_ready) state_next = ST_POP;
      ST_POP: begin
        kbd_rdn    = 1'b0;
        state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Decode the latched byte and resolve FIFO push/pop for this cycle.
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    is_ext    = (byte_reg == CODE_EXT);
    is_brk    = (byte_reg == CODE_BRK);
    push_req  = (state_reg == ST_POP) && !is_ext && !is_brk;
    fifo_full = (count_reg == COUNT_FULL);
    do_pop    = cpu_rd && (count_reg != '0);
    do_push   = push_req && (!fifo_full || do_pop);
    drop      = push_req && fifo_full && !do_pop;
  end

  // Sequencer state, captured byte and prefix flags. Flags clear after any
  // non-prefix byte, including one that was dropped on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      byte_reg  <= '0;
      ext_reg   <= 1'b0;
      brk_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && kbd_ready) byte_reg <= kbd_data;
      if (state_reg == ST_POP) begin
        if (is_ext) begin
          ext_reg <= 1'b1;
        end else if (is_brk) begin
          brk_reg <= 1'b1;
        end else begin
          ext_reg <= 1'b0;
          brk_reg <= 1'b0;
        end
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
      if (drop)         overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  // Event storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= {brk_reg, ext_reg, byte_reg};
  end

  // Head of queue is presented combinationally (fall-through), zero when empty.
  assign evt_valid = (count_reg != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr_reg] : '0;
  assign evt_count = count_reg;
  assign overflow  = overflow_reg;

endmodule
